usi_master_arbiter: RTL and testbench

USI_MASTER_ARBITER -- requirements
Module: usi_master_arbiter

---
 rtl/usi_master_arbiter.sv | 177 +++++++++++++++++
 tb/tb_usi_master_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/usi_master_arbiter.sv
// Two-master round-robin arbiter for the USI master port (master 0 = MCB, master 1 = SPI).
// Optional grant watchdog enabled by defining USI_ARB_TIMEOUT_EN.
module usi_master_arbiter #(
  parameter int unsigned pBusAdrsBit      = 16,
  parameter int unsigned pBusSlaveConnect = 9,
  parameter int unsigned pTimeout         = 1024
) (
  input  logic                        iUsiClk,
  input  logic                        iUsiRst,
  input  logic                        iM0Req,
  input  logic                        iM1Req,
  output logic                        oM0Gnt,
  output logic                        oM1Gnt,
  input  logic [31:0]                 iM0Wd,
  input  logic [31:0]                 iM1Wd,
  input  logic [pBusAdrsBit-1:0]      iM0Adrs,
  input  logic [pBusAdrsBit-1:0]      iM1Adrs,
  input  logic                        iM0WEd,
  input  logic                        iM1WEd,
  output logic [31:0]                 oMUsiWd,
  output logic [pBusAdrsBit-1:0]      oMUsiAdrs,
  output logic                        oMUsiWEd,
  input  logic [pBusSlaveConnect-1:0] iMUsiVd,
  output logic [pBusSlaveConnect-1:0] oM0Vd,
  output logic [pBusSlaveConnect-1:0] oM1Vd,
  output logic                        oTimeout
);

  if (pTimeout < 2 || pTimeout > 65535) begin : g_bad_timeout
    $error("usi_master_arbiter: pTimeout out of range 2..65535");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  state_e                  state_q, state_d;
  logic                    gnt0_q, gnt0_d;
  logic                    gnt1_q, gnt1_d;
  logic                    last_q, last_d;
  logic [31:0]             wd_q, wd_d;
  logic [pBusAdrsBit-1:0]  adrs_q, adrs_d;
  logic                    wed_q, wed_d;
  logic                    own_req;
  logic                    elig0, elig1;

`ifdef USI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(pTimeout - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        mask0_q, mask0_d;
  logic        mask1_q, mask1_d;
  logic        timeout_q, timeout_d;

  assign elig0    = iM0Req & ~mask0_q;
  assign elig1    = iM1Req & ~mask1_q;
  assign oTimeout = timeout_q;
`else
  assign elig0    = iM0Req;
  assign elig1    = iM1Req;
  assign oTimeout = 1'b0;
`endif

  assign own_req = (gnt0_q & iM0Req) | (gnt1_q & iM1Req);

  always_comb begin
    state_d = state_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    last_d  = last_q;
`ifdef USI_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    // A mask survives only while the masked master keeps its request high.
    mask0_d   = mask0_q & iM0Req;
    mask1_d   = mask1_q & iM1Req;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (elig0 && (!elig1 || last_q)) begin
          state_d = BUSY;
          gnt0_d  = 1'b1;
          last_d  = 1'b0;
`ifdef USI_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (elig1) begin
          state_d = BUSY;
          gnt1_d  = 1'b1;
          last_d  = 1'b1;
`ifdef USI_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (!own_req) begin
          state_d = RELEASE;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end
`ifdef USI_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d   = RELEASE;
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          timeout_d = 1'b1;
          if (gnt0_q) mask0_d = 1'b1;
          if (gnt1_q) mask1_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase

    // Bus registers follow the next-cycle grant so the bus is zero exactly when no grant is held.
    if (gnt0_d) begin
      wd_d   = iM0Wd;
      adrs_d = iM0Adrs;
      wed_d  = iM0WEd;
    end else if (gnt1_d) begin
      wd_d   = iM1Wd;
      adrs_d = iM1Adrs;
      wed_d  = iM1WEd;
    end else begin
      wd_d   = '0;
      adrs_d = '0;
      wed_d  = 1'b0;
    end
  end

  always_ff @(posedge iUsiClk) begin
    if (iUsiRst) begin
      state_q   <= IDLE;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      last_q    <= 1'b1;
      wd_q      <= '0;
      adrs_q    <= '0;
      wed_q     <= 1'b0;
`ifdef USI_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      mask0_q   <= 1'b0;
      mask1_q   <= 1'b0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      adrs_q    <= adrs_d;
      wed_q     <= wed_d;
`ifdef USI_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      mask0_q   <= mask0_d;
      mask1_q   <= mask1_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign oM0Gnt    = gnt0_q;
  assign oM1Gnt    = gnt1_q;
  assign oMUsiWd   = wd_q;
  assign oMUsiAdrs = adrs_q;
  assign oMUsiWEd  = wed_q;
  assign oM0Vd     = gnt0_q ? iMUsiVd : '0;
  assign oM1Vd     = gnt1_q ? iMUsiVd : '0;

endmodule

// File: tb/tb_usi_master_arbiter.sv
// Directed testbench for usi_master_arbiter (pTimeout = 8; watchdog tests follow USI_ARB_TIMEOUT_EN).
module tb_usi_master_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m1_req;
  logic        m0_gnt, m1_gnt;
  logic [31:0] m0_wd, m1_wd, bus_wd;
  logic [15:0] m0_adrs, m1_adrs, bus_adrs;
  logic        m0_wed, m1_wed, bus_wed;
  logic [8:0]  bus_vd, m0_vd, m1_vd;
  logic        tmo;

  int errors = 0;
  int checks = 0;

  usi_master_arbiter #(
    .pBusAdrsBit      (16),
    .pBusSlaveConnect (9),
    .pTimeout         (8)
  ) dut (
    .iUsiClk   (clk),
    .iUsiRst   (rst),
    .iM0Req    (m0_req),
    .iM1Req    (m1_req),
    .oM0Gnt    (m0_gnt),
    .oM1Gnt    (m1_gnt),
    .iM0Wd     (m0_wd),
    .iM1Wd     (m1_wd),
    .iM0Adrs   (m0_adrs),
    .iM1Adrs   (m1_adrs),
    .iM0WEd    (m0_wed),
    .iM1WEd    (m1_wed),
    .oMUsiWd   (bus_wd),
    .oMUsiAdrs (bus_adrs),
    .oMUsiWEd  (bus_wed),
    .iMUsiVd   (bus_vd),
    .oM0Vd     (m0_vd),
    .oM1Vd     (m1_vd),
    .oTimeout  (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 1'b0; m1_req = 1'b0;
    m0_wd = '0; m1_wd = '0; m0_adrs = '0; m1_adrs = '0;
    m0_wed = 1'b0; m1_wed = 1'b0; bus_vd = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus_vd = 9'h1FF;
    step();
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt}); end
    checks++; if ({bus_wd, bus_adrs, bus_wed} !== 49'h0) begin errors++; $display("FAIL reset_bus: got %h/%h/%b expected 0", bus_wd, bus_adrs, bus_wed); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", tmo); end
    checks++; if ({m0_vd, m1_vd} !== 18'h0) begin errors++; $display("FAIL reset_vd: got %h/%h expected 0", m0_vd, m1_vd); end
    rst = 1'b0;
    bus_vd = '0;
  endtask

  task automatic test_single_grant();
    do_reset();
    m0_req = 1'b1; m0_adrs = 16'h1234; m0_wd = 32'hDEADBEEF; m0_wed = 1'b1;
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL single_gnt: got %b expected 10", {m0_gnt, m1_gnt}); end
    checks++; if (bus_adrs !== 16'h1234) begin errors++; $display("FAIL single_adrs: got %h expected 1234", bus_adrs); end
    checks++; if (bus_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wd: got %h expected deadbeef", bus_wd); end
    checks++; if (bus_wed !== 1'b1) begin errors++; $display("FAIL single_wed: got %b expected 1", bus_wed); end
    m0_adrs = 16'h00A5; m0_wed = 1'b0;
    checks++; if (bus_adrs !== 16'h1234) begin errors++; $display("FAIL adrs_latency: got %h expected 1234", bus_adrs); end
    step();
    checks++; if ({bus_adrs, bus_wed} !== {16'h00A5, 1'b0}) begin errors++; $display("FAIL adrs_update: got %h/%b expected 00a5/0", bus_adrs, bus_wed); end
    bus_vd = 9'h155;
    #1;
    checks++; if ({m0_vd, m1_vd} !== {9'h155, 9'h000}) begin errors++; $display("FAIL vd_route_m0: got %h/%h expected 155/000", m0_vd, m1_vd); end
    m0_req = 1'b0; m0_wed = 1'b1;
    step();
    checks++; if ({m0_gnt, m1_gnt, bus_wed} !== 3'b000) begin errors++; $display("FAIL release_state: got %b expected 000", {m0_gnt, m1_gnt, bus_wed}); end
    checks++; if ({bus_wd, bus_adrs} !== 48'h0) begin errors++; $display("FAIL release_bus: got %h/%h expected 0", bus_wd, bus_adrs); end
    checks++; if (m0_vd !== 9'h000) begin errors++; $display("FAIL release_vd: got %h expected 000", m0_vd); end
    clear_inputs();
  endtask

  task automatic test_arbitration();
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1;
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL tie_first_m0: got %b expected 10", {m0_gnt, m1_gnt}); end
    step(); step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL no_preempt: got %b expected 10", {m0_gnt, m1_gnt}); end
    m0_req = 1'b0;
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL gap_cycle1: got %b expected 00", {m0_gnt, m1_gnt}); end
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL gap_cycle2: got %b expected 00", {m0_gnt, m1_gnt}); end
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL m1_after_gap: got %b expected 01", {m0_gnt, m1_gnt}); end
    m0_req = 1'b1;
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL m1_hold: got %b expected 01", {m0_gnt, m1_gnt}); end
    m1_req = 1'b0;
    step(); step(); step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL m0_after_m1: got %b expected 10", {m0_gnt, m1_gnt}); end
    m1_req = 1'b1; m0_req = 1'b0;
    step();
    m0_req = 1'b1;
    step(); step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL tie_rotate_m1: got %b expected 01", {m0_gnt, m1_gnt}); end
    clear_inputs();
  endtask

  task automatic test_isolation();
    do_reset();
    m1_req = 1'b1; m1_adrs = 16'h0A0A; m1_wd = 32'h11112222; m1_wed = 1'b0;
    m0_wed = 1'b1; m0_adrs = 16'h0501; m0_wd = 32'hFFFF0000;
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL iso_gnt: got %b expected 01", {m0_gnt, m1_gnt}); end
    checks++; if ({bus_wd, bus_adrs, bus_wed} !== {32'h11112222, 16'h0A0A, 1'b0}) begin errors++; $display("FAIL iso_bus: got %h/%h/%b expected 11112222/0a0a/0", bus_wd, bus_adrs, bus_wed); end
    bus_vd = 9'h001;
    m1_wed = 1'b1;
    #1;
    checks++; if ({m0_vd, m1_vd} !== {9'h000, 9'h001}) begin errors++; $display("FAIL iso_vd: got %h/%h expected 000/001", m0_vd, m1_vd); end
    step();
    checks++; if (bus_wed !== 1'b1) begin errors++; $display("FAIL iso_wed_follow: got %b expected 1", bus_wed); end
    m1_wed = 1'b0;
    step();
    checks++; if (bus_wed !== 1'b0) begin errors++; $display("FAIL iso_wed_m0_blocked: got %b expected 0", bus_wed); end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    m1_req = 1'b1; m1_adrs = 16'hBEEF; m1_wd = 32'hCAFE0001; m1_wed = 1'b1;
    step();
    step();
    checks++; if ({m1_gnt, bus_wed, bus_adrs} !== {1'b1, 1'b1, 16'hBEEF}) begin errors++; $display("FAIL pre_reset_busy: got %b/%b/%h expected 1/1/beef", m1_gnt, bus_wed, bus_adrs); end
    m0_req = 1'b1;
    bus_vd = 9'h1FF;
    rst = 1'b1;
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL mid_reset_gnt: got %b expected 00", {m0_gnt, m1_gnt}); end
    checks++; if ({bus_wd, bus_adrs, bus_wed} !== 49'h0) begin errors++; $display("FAIL mid_reset_bus: got %h/%h/%b expected 0", bus_wd, bus_adrs, bus_wed); end
    checks++; if ({m0_vd, m1_vd} !== 18'h0) begin errors++; $display("FAIL mid_reset_vd: got %h/%h expected 0", m0_vd, m1_vd); end
    rst = 1'b0;
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL tie_after_reset: got %b expected 10", {m0_gnt, m1_gnt}); end
    clear_inputs();
  endtask

`ifdef USI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_req = 1'b1;
    step();
    checks++; if ({m0_gnt, tmo} !== 2'b10) begin errors++; $display("FAIL to_grant: got %b expected 10", {m0_gnt, tmo}); end
    for (int i = 0; i < 7; i++) step();
    checks++; if ({m0_gnt, tmo} !== 2'b10) begin errors++; $display("FAIL to_before_limit: got %b expected 10", {m0_gnt, tmo}); end
    step();
    checks++; if ({m0_gnt, m1_gnt, tmo} !== 3'b001) begin errors++; $display("FAIL to_pulse: got %b expected 001", {m0_gnt, m1_gnt, tmo}); end
    m1_req = 1'b1;
    step();
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b expected 0", tmo); end
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL to_m1_wins: got %b expected 01", {m0_gnt, m1_gnt}); end
    m1_req = 1'b0;
    step(); step(); step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL to_m0_masked: got %b expected 00", {m0_gnt, m1_gnt}); end
    m0_req = 1'b0;
    step();
    m0_req = 1'b1;
    step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL to_unmask: got %b expected 10", {m0_gnt, m1_gnt}); end
    clear_inputs();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    m0_req = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if ({m0_gnt, tmo} !== 2'b10) begin errors++; $display("FAIL hold_forever cycle %0d: got %b expected 10", i, {m0_gnt, tmo}); end
    end
    clear_inputs();
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_grant();
    test_arbitration();
    test_isolation();
    test_reset_mid_busy();
`ifdef USI_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
